// File: rtl/rvfi_imem_bus_pkg.sv
// Shared definitions for the formal instruction-fetch stub and its checker.
// Holds the default address width and the pinned-halfword substitution function.
package rvfi_imem_bus_pkg;

  localparam int unsigned IMEM_XLEN = 32;

  localparam int unsigned IMEM_MAX_XLEN = 64;

  // Addresses arrive zero-extended to 64 bits; xlen masks the addr+2 wrap so
  // the top halfword of the address space pairs with address 0.
  function automatic logic [31:0] imem_subst(
    input logic [63:0]  addr,
    input logic [63:0]  pin_addr,
    input logic [15:0]  pin_data,
    input logic [31:0]  fill,
    input int unsigned  xlen
  );
    logic [63:0] mask;
    logic [63:0] hi_addr;
    logic [31:0] word;
    mask    = (xlen >= IMEM_MAX_XLEN) ? '1 : ((64'd1 << xlen) - 64'd1);
    hi_addr = (addr + 64'd2) & mask;
    word[15:0]  = ((addr & mask) == (pin_addr & mask)) ? pin_data : fill[15:0];
    word[31:16] = (hi_addr == (pin_addr & mask)) ? pin_data : fill[31:16];
    return word;
  endfunction

endpackage

// File: rtl/rvfi_imem_fifo.sv
// In-order circular FIFO where each entry carries a latency countdown; the
// head is only presented once its countdown has reached zero.
module rvfi_imem_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned WIDTH   = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH) + 1;
  localparam int unsigned AW   = $clog2(LATENCY + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [AW-1:0]    age_q  [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CNTW-1:0]  count_q;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      if (push) tail_q <= next_ptr(tail_q);
      if (pop)  head_q <= next_ptr(head_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Free slots always hold age 0 (only aged-out entries are popped), so
      // ageing every non-zero slot is the same as ageing occupied ones.
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (tail_q == PW'(i))) age_q[i] <= AW'(LATENCY - 1);
        else if (age_q[i] != '0)        age_q[i] <= age_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) data_q[tail_q] <= push_data;
  end

  assign full       = (count_q == CNTW'(DEPTH));
  assign head_valid = (count_q != '0) && (age_q[head_q] == '0);
  assign head_data  = data_q[head_q];

endmodule

// File: rtl/rvfi_imem_bus.sv
// Instruction-fetch stub for the formal harness: the halfword at imem_addr
// always reads as imem_data, everything else comes from fill_data.
module rvfi_imem_bus
  import rvfi_imem_bus_pkg::*;
#(
  parameter int unsigned XLEN    = IMEM_XLEN,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic [31:0]     fill_data,
  input  logic            stall,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_data,
  output logic            resp_err
);

  logic        push;
  logic        pop;
  logic        full;
  logic        head_valid;
  logic [31:0] subst_word;
  logic [32:0] push_entry;
  logic [32:0] head_entry;

  // Both sides transfer on valid && ready. req_ready depends only on occupancy
  // and stall (never on resp_ready); resp_valid/data/err stay put until popped.
  assign req_ready  = !reset && !stall && !full;
  assign push       = req_valid && req_ready;
  assign resp_valid = !reset && head_valid;
  assign pop        = resp_valid && resp_ready;

  assign subst_word = imem_subst(64'(req_addr), 64'(imem_addr), imem_data,
                                 fill_data, XLEN);
  // Misaligned fetches return the raw fill word with the error flag set.
  assign push_entry = {(req_addr[0] ? fill_data : subst_word), req_addr[0]};

  rvfi_imem_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .WIDTH   (33)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .full       (full),
    .head_valid (head_valid),
    .head_data  (head_entry)
  );

  assign resp_data = resp_valid ? head_entry[32:1] : 32'd0;
  assign resp_err  = resp_valid ? head_entry[0]    : 1'b0;

endmodule

// File: tb/tb_rvfi_imem_bus.sv
// Directed bench for rvfi_imem_bus: one LATENCY=1 instance and one LATENCY=3
// instance share all inputs; each section resets before it starts.
module tb_rvfi_imem_bus;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic [31:0] fill_data;
  logic        stall;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        resp_ready;

  logic        req_ready,  resp_valid,  resp_err;
  logic [31:0] resp_data;
  logic        req_ready3, resp_valid3, resp_err3;
  logic [31:0] resp_data3;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  rvfi_imem_bus #(.XLEN(32), .DEPTH(4), .LATENCY(1)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .fill_data(fill_data), .stall(stall), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err)
  );

  rvfi_imem_bus #(.XLEN(32), .DEPTH(4), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .fill_data(fill_data), .stall(stall), .req_valid(req_valid),
    .req_ready(req_ready3), .req_addr(req_addr), .resp_valid(resp_valid3),
    .resp_ready(resp_ready), .resp_data(resp_data3), .resp_err(resp_err3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drivers: inputs change on the falling edge, outputs sampled 1ns later
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; stall = 1'b0;
    #1;
    check({tag, "_rst_req_ready"},  32'(req_ready),  32'd0);
    check({tag, "_rst_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_rst_resp_data"},  resp_data,       32'd0);
    check({tag, "_rst_resp_err"},   32'(resp_err),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic req_cycle(input logic [31:0] a, input logic [31:0] f,
                           input logic exp_rdy, input string tag);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; fill_data = f;
    #1;
    check({tag, "_req_ready"}, 32'(req_ready), 32'(exp_rdy));
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    #1;
  endtask

  task automatic check_resp(input string tag, input logic v, input logic [31:0] d, input logic e);
    check({tag, "_valid"}, 32'(resp_valid), 32'(v));
    check({tag, "_data"},  resp_data,       d);
    check({tag, "_err"},   32'(resp_err),   32'(e));
  endtask

  // Fill past DEPTH with resp_ready low, hold, then drain against exp_q.
  task automatic burst(input logic [31:0] base, input string tag);
    logic [31:0] f;
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      f = 32'h5A00_0000 + base + 32'(i);
      req_cycle(base + 32'(4 * i), f, (i < 4), {tag, "_fill"});
      if (i < 4) exp_q.push_back(f);
    end
    idle();
    check_resp({tag, "_hold0"}, 1'b1, exp_q[0], 1'b0);
    idle();
    check_resp({tag, "_hold1"}, 1'b1, exp_q[0], 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      resp_ready = 1'b1;
      #1;
      if (i == 0) check({tag, "_full_while_pop"}, 32'(req_ready), 32'd0);
      check_resp({tag, "_drain"}, 1'b1, exp_q.pop_front(), 1'b0);
    end
    idle();
    check({tag, "_empty"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; imem_addr = '0; imem_data = '0; fill_data = '0;
    stall = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    do_reset("init");

    // pinned low half
    imem_addr = 32'h100; imem_data = 16'hA5A5; resp_ready = 1'b1;
    req_cycle(32'h100, 32'h1234_5678, 1'b1, "lo");
    idle();
    check_resp("lo", 1'b1, 32'h1234_A5A5, 1'b0);
    idle();
    check("lo_popped", 32'(resp_valid), 32'd0);

    // pinned high half through address wrap, then a non-pinned neighbour
    imem_addr = 32'h0; imem_data = 16'hBEEF;
    req_cycle(32'hFFFF_FFFE, 32'h1111_2222, 1'b1, "hi_wrap");
    idle();
    check_resp("hi_wrap", 1'b1, 32'hBEEF_2222, 1'b0);
    req_cycle(32'h102, 32'h1111_2222, 1'b1, "plain");
    idle();
    check_resp("plain", 1'b1, 32'h1111_2222, 1'b0);

    // value frozen at accept despite later pin changes
    idle();
    imem_addr = 32'h100; imem_data = 16'hA5A5; resp_ready = 1'b0;
    req_cycle(32'hFE, 32'h0, 1'b1, "frozen");
    idle();
    imem_addr = 32'h400; imem_data = 16'h0000;
    idle();
    check_resp("frozen", 1'b1, 32'hA5A5_0000, 1'b0);
    @(negedge clk);
    resp_ready = 1'b1;
    idle();
    check("frozen_popped", 32'(resp_valid), 32'd0);

    // misaligned
    req_cycle(32'h101, 32'hCAFE_F00D, 1'b1, "misal");
    idle();
    check_resp("misal", 1'b1, 32'hCAFE_F00D, 1'b1);
    idle();

    // full FIFO and back-pressure
    imem_addr = 32'h200; imem_data = 16'h7777;
    burst(32'h10, "full");

    // reset with entries in flight
    @(negedge clk);
    resp_ready = 1'b0;
    req_cycle(32'h40, 32'hAAAA_0001, 1'b1, "mid");
    req_cycle(32'h44, 32'hAAAA_0002, 1'b1, "mid");
    req_cycle(32'h48, 32'hAAAA_0003, 1'b1, "mid");
    do_reset("mid");
    check("mid_post_valid", 32'(resp_valid), 32'd0);
    check("mid_post_ready", 32'(req_ready),  32'd1);
    resp_ready = 1'b1;
    req_cycle(32'h300, 32'h3333_4444, 1'b1, "post");
    idle();
    check_resp("post", 1'b1, 32'h3333_4444, 1'b0);
    burst(32'h60, "post");

    // stall and LATENCY=3 timing
    do_reset("lat3");
    resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      stall = 1'b1; req_valid = 1'b1; req_addr = 32'h500; fill_data = 32'h0BAD_F00D;
      #1;
      check("stall_ready3", 32'(req_ready3), 32'd0);
      check("stall_ready1", 32'(req_ready),  32'd0);
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    check("lat3_accept", 32'(req_ready3), 32'd1);
    idle();
    check("lat3_t1", 32'(resp_valid3), 32'd0);
    idle();
    check("lat3_t2", 32'(resp_valid3), 32'd0);
    idle();
    check("lat3_t3_valid", 32'(resp_valid3), 32'd1);
    check("lat3_t3_data",  resp_data3,       32'h0BAD_F00D);
    check("lat3_t3_err",   32'(resp_err3),   32'd0);
    idle();
    check("lat3_popped", 32'(resp_valid3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvfi_imem_bus.md
Name: rvfi_imem_bus

Overview:
- Formal-harness instruction-fetch memory stub that sits directly upstream of the core under test and feeds its fetch port.
- It serves 32-bit fetch words in which the halfword at the checker's constant address imem_addr always reads as imem_data. All other halfwords come from the harness-driven fill_data input, which is unconstrained in formal.
- This makes rvfi_insn at retirement checkable against a single pinned halfword. Responses are in order, with configurable latency and outstanding depth.

Parameters:
- XLEN, 32, address width; matches RISCV_FORMAL_XLEN.
- DEPTH, 4, maximum outstanding requests; power of two, at least 1.
- LATENCY, 1, minimum cycles from request accept to response valid; at least 1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- imem_addr  input  XLEN  pinned halfword address from the checker; bit0 always 0
- imem_data  input  16  pinned halfword value from the checker
- fill_data  input  32  free data for non-pinned halfwords; sampled at accept
- stall  input  1  harness-injected back-pressure on the request side
- req_valid  input  1  core fetch request
- req_ready  output  1  request accepted when req_valid && req_ready
- req_addr  input  XLEN  fetch address
- resp_valid  output  1  response available
- resp_ready  input  1  core consumes the response when resp_valid && resp_ready
- resp_data  output  32  fetch word; [15:0] at addr, [31:16] at addr+2
- resp_err  output  1  misaligned fetch (req_addr[0]==1)

Behaviour:
- Storage: a circular FIFO of DEPTH entries. Each entry holds {data[31:0], err, cnt}, where cnt is $clog2(LATENCY+1) bits. The FIFO has head and tail pointers and a count of width $clog2(DEPTH)+1.
- Reset (sync, active-high): count=0, head=tail=0, all cnt=0. Outputs req_ready=0, resp_valid=0, resp_data=0, resp_err=0 during the reset cycle. Reset mid-operation drops all outstanding entries; no response for them is ever produced.
- req_ready = !reset && !stall && (count < DEPTH). Combinational. It does not depend on a same-cycle pop, so a full FIFO refuses a push even while popping.
- Accept: the entry is written at tail.
  - lo = (req_addr == imem_addr) ? imem_data : fill_data[15:0]
  - hi = (req_addr+2 == imem_addr) ? imem_data : fill_data[31:16]; the addition is mod 2^XLEN, so addr 0xFFFF_FFFE makes hi address 0.
  - err = req_addr[0]. When err=1, data = fill_data with no substitution.
  - cnt = LATENCY-1.
  - Values are frozen at accept; later changes of imem_addr or imem_data do not affect a stored entry.
- Aging: every cycle, each occupied entry with cnt != 0 decrements by 1 and saturates at 0. The entry written in the current cycle does not age in that cycle.
- Response: resp_valid = (count != 0) && (head.cnt == 0). resp_data and resp_err are driven from the head entry when resp_valid=1, and are 0 otherwise.
  - Pop on resp_valid && resp_ready. Head advances mod DEPTH.
  - Latency is exactly LATENCY cycles after accept when the FIFO was empty and resp_ready is held high. Responses are strictly in request order.
- Handshake stability: while resp_valid=1 && resp_ready=0, resp_valid, resp_data and resp_err hold steady. stall never affects the response side.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Pointer wrap: tail and head wrap at DEPTH. No entry is overwritten, because the push is blocked when full.
- No combinational path from resp_ready to req_ready.

Decomposition:
- Shared package/include: the XLEN default tied to RISCV_FORMAL_XLEN, and a function imem_subst(addr, imem_addr, imem_data, fill) that returns the 32-bit substituted word. rvfi_imem_check reuses it for reference modelling.
- One natural sub-module: rvfi_imem_fifo, a parameterised in-order FIFO with per-entry latency countdown. The top level holds only the substitution and the port glue.

Test Plan:
- Pinned low half: imem_addr=0x100, imem_data=0xA5A5, fill=0x1234_5678, request 0x100 with LATENCY=1 -> one cycle later resp_data=0x1234_A5A5, err=0.
- Pinned high half and wrap: imem_addr=0x0, imem_data=0xBEEF, request 0xFFFF_FFFE with fill=0x1111_2222 -> resp_data=0xBEEF_2222. A request at 0x102 with the same fill -> resp_data=0x1111_2222.
- Full and back-pressure: DEPTH=4, resp_ready=0, 5 back-to-back requests -> 4 accepted, req_ready=0 on the 5th. The first response is held stable. Releasing resp_ready -> 4 in-order responses on consecutive cycles.
- Latency and stall: LATENCY=3, stall=1 for 2 cycles with req_valid=1 -> no accept. After stall drops, accept at cycle t -> resp_valid first at t+3.
- Misaligned: req_addr=0x101, fill=0xCAFE_F00D -> resp_err=1, resp_data=0xCAFE_F00D.
- Reset mid-flight: 3 outstanding entries, reset pulsed for 1 cycle -> resp_valid=0 afterwards, count=0, the next request is served with the original latency.
